// File: rtl/relu_layer_ctrl.sv
// ReLU layer controller: streams len words from a source buffer through a small FIFO, writes max(x,0) to a destination.
// Latency: first read 1 cycle after start; each word written 2 cycles after its read; done 1 cycle after last write.
// Backpressure: wr_ready low holds the FIFO head; reads stop once FIFO occupancy plus reads in flight reaches 4.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, len, src_base,    - pass request; len/bases sampled when start is taken in IDLE
//   dst_base
//   rd_en, rd_addr, rd_data  - source read port, data returns exactly 1 cycle after rd_en
//   wr_en, wr_ready,         - destination write port, valid/ready handshake
//   wr_addr, wr_data
//   busy, done, clip_cnt     - pass status, end-of-pass pulse, number of negative inputs zeroed

// Small generic FIFO; DEPTH must be a power of two. count is the registered occupancy.
module relu_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign head_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

module relu_layer_ctrl #(
    parameter int WIDTH  = 20,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] clip_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] issue_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic              inflight;   // a read issued last cycle; its data is on rd_data now
    logic [WIDTH-1:0]  head_dat;
    logic [2:0]        fifo_cnt;
    logic              head_neg;
    logic              wr_acc;

    relu_fifo #(.WIDTH(WIDTH), .DEPTH(4)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat (rd_data),
        .pop      (wr_acc),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    // Counting the in-flight read against the 4 slots guarantees the returning word always has room.
    assign rd_en    = (state == RUN) && (issue_cnt < len_q) &&
                      ((fifo_cnt + {2'b00, inflight}) < 3'd4);
    assign rd_addr  = src_q + issue_cnt;
    assign wr_addr  = dst_q + wr_cnt;
    assign wr_en    = (fifo_cnt != 3'd0);
    assign head_neg = head_dat[WIDTH-1];
    // Forced to zero when empty so stale FIFO contents never appear on the bus.
    assign wr_data  = (wr_en && !head_neg) ? head_dat : '0;
    assign wr_acc   = wr_en && wr_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            issue_cnt <= '0;
            wr_cnt    <= '0;
            clip_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                issue_cnt <= issue_cnt + ADDR_W'(1);
            end
            if (wr_acc) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
                if (head_neg) begin
                    clip_cnt <= clip_cnt + ADDR_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        clip_cnt <= '0;
                        if (len != '0) begin
                            len_q     <= len;
                            src_q     <= src_base;
                            dst_q     <= dst_base;
                            issue_cnt <= '0;
                            wr_cnt    <= '0;
                            state     <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (rd_en && (issue_cnt == len_q - ADDR_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_acc && (wr_cnt == len_q - ADDR_W'(1))) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_relu_layer_ctrl.sv
// Directed bench for relu_layer_ctrl: source memory model, logged reads/writes with cycle numbers relative to start.
// Cycle 0 is the cycle in which start is high; inputs change on the falling edge, logs sample 1 ns later.
// Expected values are hand-computed constants per scenario.
module tb_relu_layer_ctrl;
    localparam int WIDTH  = 20;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] len = '0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data = '0;
    logic              wr_en;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] clip_cnt;

    relu_layer_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .src_base (src_base),
        .dst_base (dst_base),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .clip_cnt (clip_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory: data valid exactly one cycle after rd_en, junk otherwise.
    logic [WIDTH-1:0] src_mem [1024];
    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[rd_addr];
        else       rd_data <= 20'hABCDE;
    end

    int t0 = 0;
    int stall_lo = 100;
    int stall_hi = -1;
    int rd_cyc[$];
    int rd_adr[$];
    int wr_cyc[$];
    int wr_adr[$];
    int wr_dat[$];
    int done_cyc[$];

    always @(negedge clk) begin
        #1;
        if (rd_en) begin
            rd_cyc.push_back(cyc - t0);
            rd_adr.push_back(int'(rd_addr));
        end
        if (wr_en && wr_ready) begin
            wr_cyc.push_back(cyc - t0);
            wr_adr.push_back(int'(wr_addr));
            wr_dat.push_back(int'(wr_data));
        end
        if (done) done_cyc.push_back(cyc - t0);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_adr.delete();
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        done_cyc.delete();
    endtask

    // Leaves the bench at the falling edge of cycle 1 with start low.
    task automatic start_pass(input int l, input int s, input int d);
        @(negedge clk);
        clear_logs();
        start = 1'b1;
        len = ADDR_W'(l);
        src_base = ADDR_W'(s);
        dst_base = ADDR_W'(d);
        wr_ready = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen = 0;
        int rel;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            wr_ready = !(rel >= stall_lo && rel <= stall_hi);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        wr_ready = 1'b1;
    endtask

    logic [WIDTH-1:0] exp1 [4];
    logic [WIDTH-1:0] exp2 [8];
    logic [WIDTH-1:0] exp4 [4];
    int rd2 [8];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) src_mem[i] = '0;
        src_mem[10'h010] = 20'h00005; src_mem[10'h011] = 20'hFFFFD;
        src_mem[10'h012] = 20'h00000; src_mem[10'h013] = 20'h7FFFF;
        exp1 = '{20'h00005, 20'h00000, 20'h00000, 20'h7FFFF};
        src_mem[10'h040] = 20'h00001; src_mem[10'h041] = 20'h80000;
        src_mem[10'h042] = 20'h00002; src_mem[10'h043] = 20'hFFFFF;
        src_mem[10'h044] = 20'h7FFFF; src_mem[10'h045] = 20'h00000;
        src_mem[10'h046] = 20'h12345; src_mem[10'h047] = 20'h80001;
        exp2 = '{20'h00001, 20'h0, 20'h00002, 20'h0, 20'h7FFFF, 20'h0, 20'h12345, 20'h0};
        rd2  = '{1, 2, 3, 4, 11, 12, 13, 14};
        src_mem[10'h3FE] = 20'h00011; src_mem[10'h3FF] = 20'h80022;
        src_mem[10'h000] = 20'h00033; src_mem[10'h001] = 20'h00044;
        exp4 = '{20'h00011, 20'h0, 20'h00033, 20'h00044};
        for (int i = 0; i < 6; i++) src_mem[10'h100 + i] = WIDTH'(i + 1);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {28'd0, rd_en, wr_en, busy, done}, 32'd0);
        chk("rst_clip", 32'(clip_cnt), 32'd0);
        chk("rst_addr", {12'd0, rd_addr, wr_addr}, 32'd0);
        chk("rst_wdat", 32'(wr_data), 32'd0);

        // Basic pass with clipping
        start_pass(4, 'h010, 'h020);
        chk("t1_busy_c1", 32'(busy), 32'd1);
        wait_done("t1", 40);
        chk("t1_rd_n", rd_cyc.size(), 4);
        chk("t1_wr_n", wr_cyc.size(), 4);
        for (int i = 0; i < 4 && i < rd_cyc.size() && i < wr_cyc.size(); i++) begin
            chk($sformatf("t1_rd_cyc%0d", i), rd_cyc[i], i + 1);
            chk($sformatf("t1_rd_adr%0d", i), rd_adr[i], 'h010 + i);
            chk($sformatf("t1_wr_cyc%0d", i), wr_cyc[i], i + 3);
            chk($sformatf("t1_wr_adr%0d", i), wr_adr[i], 'h020 + i);
            chk($sformatf("t1_wr_dat%0d", i), wr_dat[i], int'(exp1[i]));
        end
        chk("t1_done_n", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0], 7);
        chk("t1_clip", 32'(clip_cnt), 32'd1);
        chk("t1_idle", {30'd0, busy, done}, 32'd0);

        // Backpressure: wr_ready low cycles 2-9
        stall_lo = 2; stall_hi = 9;
        start_pass(8, 'h040, 'h080);
        wait_done("t2", 60);
        stall_lo = 100; stall_hi = -1;
        chk("t2_rd_n", rd_cyc.size(), 8);
        for (int i = 0; i < 8 && i < rd_cyc.size(); i++) begin
            chk($sformatf("t2_rd_cyc%0d", i), rd_cyc[i], rd2[i]);
            chk($sformatf("t2_rd_adr%0d", i), rd_adr[i], 'h040 + i);
        end
        chk("t2_wr_n", wr_cyc.size(), 8);
        for (int i = 0; i < 8 && i < wr_cyc.size(); i++) begin
            chk($sformatf("t2_wr_cyc%0d", i), wr_cyc[i], 10 + i);
            chk($sformatf("t2_wr_adr%0d", i), wr_adr[i], 'h080 + i);
            chk($sformatf("t2_wr_dat%0d", i), wr_dat[i], int'(exp2[i]));
        end
        if (done_cyc.size() > 0) chk("t2_done_cyc", done_cyc[0], 18);
        chk("t2_clip", 32'(clip_cnt), 32'd3);

        // Zero-length pass
        start_pass(0, 'h010, 'h020);
        chk("t3_c1", {30'd0, busy, done}, 32'd3);
        chk("t3_clip_clr", 32'(clip_cnt), 32'd0);
        @(negedge clk);
        chk("t3_c2", {30'd0, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_rd_n", rd_cyc.size(), 0);
        chk("t3_wr_n", wr_cyc.size(), 0);
        chk("t3_done_n", done_cyc.size(), 1);

        // Address wrap
        start_pass(4, 'h3FE, 'h3FF);
        wait_done("t4", 40);
        chk("t4_rd_n", rd_adr.size(), 4);
        chk("t4_wr_n", wr_adr.size(), 4);
        for (int i = 0; i < 4 && i < rd_adr.size() && i < wr_adr.size(); i++) begin
            chk($sformatf("t4_rd_adr%0d", i), rd_adr[i], (('h3FE + i) % 1024));
            chk($sformatf("t4_wr_adr%0d", i), wr_adr[i], (('h3FF + i) % 1024));
            chk($sformatf("t4_wr_dat%0d", i), wr_dat[i], int'(exp4[i]));
        end
        chk("t4_clip", 32'(clip_cnt), 32'd1);

        // start during RUN is ignored
        start_pass(6, 'h100, 'h200);
        @(negedge clk);
        start = 1'b1; len = 10'd2; src_base = 10'h300; dst_base = 10'h300;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", 40);
        chk("t5_wr_n", wr_cyc.size(), 6);
        for (int i = 0; i < 6 && i < wr_cyc.size(); i++) begin
            chk($sformatf("t5_wr_adr%0d", i), wr_adr[i], 'h200 + i);
            chk($sformatf("t5_wr_dat%0d", i), wr_dat[i], i + 1);
        end
        if (done_cyc.size() > 0) chk("t5_done_cyc", done_cyc[0], 9);
        chk("t5_done_n", done_cyc.size(), 1);

        // Reset mid-RUN aborts, in-flight data discarded
        start_pass(8, 'h040, 'h080);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        chk("t6_ctl", {28'd0, rd_en, wr_en, busy, done}, 32'd0);
        chk("t6_clip", 32'(clip_cnt), 32'd0);
        chk("t6_addr", {12'd0, rd_addr, wr_addr}, 32'd0);
        chk("t6_wdat", 32'(wr_data), 32'd0);
        repeat (10) @(negedge clk);
        chk("t6_wr_after", wr_cyc.size(), 0);
        chk("t6_done_after", done_cyc.size(), 0);

        // Reset wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1; len = 10'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("t7_rst_prio", {30'd0, busy, rd_en}, 32'd0);
        @(negedge clk);
        chk("t7_still_idle", 32'(busy), 32'd0);

        // Normal pass after abort
        start_pass(2, 'h010, 'h020);
        wait_done("t8", 40);
        chk("t8_wr_n", wr_cyc.size(), 2);
        if (wr_dat.size() == 2) begin
            chk("t8_wr_dat0", wr_dat[0], 5);
            chk("t8_wr_dat1", wr_dat[1], 0);
        end
        if (done_cyc.size() > 0) chk("t8_done_cyc", done_cyc[0], 5);
        chk("t8_clip", 32'(clip_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
